// File: rtl/lcd_fetch_pkg.sv
// Shared types for the LCD framebuffer fetch stage: fetch FSM states,
// the 24-bit RGB pixel and the colour field positions inside it.
package lcd_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      FLUSH
   } fetch_state_t;

   typedef logic [23:0] pixel_t;

   localparam int unsigned RED_HI   = 23;
   localparam int unsigned RED_LO   = 16;
   localparam int unsigned GREEN_HI = 15;
   localparam int unsigned GREEN_LO = 8;
   localparam int unsigned BLUE_HI  = 7;
   localparam int unsigned BLUE_LO  = 0;

endpackage

// File: rtl/lcd_pixel_fetch_pixel_fifo.sv
// Synchronous pixel FIFO: simultaneous push/pop, occupancy count and a
// single-cycle flush. DEPTH must be a power of two.
module pixel_fifo
   import lcd_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 256
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         push,
   input  pixel_t                       push_data,
   input  logic                         pop,
   input  logic                         flush,
   output pixel_t                       head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   pixel_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (push && !flush) mem[wr_ptr] <= push_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/lcd_pixel_fetch.sv
// Framebuffer read stage: burst-prefetches pixels over Avalon-MM into a FIFO
// and pops one per visible tick. Define LCD_FETCH_DOUBLE_BUFFER_EN for page flip.
module lcd_pixel_fetch
   import lcd_fetch_pkg::*;
#(
   parameter logic [31:0] FB_BASE         = 32'h0000_0000,
   parameter logic [31:0] FB_BASE1        = 32'h0020_0000,
   parameter int unsigned H_ACT           = 800,
   parameter int unsigned V_ACT           = 480,
   parameter int unsigned FIFO_DEPTH      = 256,
   parameter int unsigned BURST           = 32,
   parameter logic [23:0] UNDERFLOW_COLOR = 24'hFF00FF
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        tick,
   input  logic        data_enable,
   input  logic        next_frame,
   input  logic        fb_select,
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic [5:0]  avm_burstcount,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid,
   output logic [7:0]  lcd_red,
   output logic [7:0]  lcd_green,
   output logic [7:0]  lcd_blue,
   output logic        underflow
);

   localparam int unsigned TOTAL = H_ACT * V_ACT;
   localparam int unsigned FET_W = $clog2(TOTAL + 1);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned DIS_W = $clog2(2 * FIFO_DEPTH + 1);

   fetch_state_t      state, state_next;
   logic [31:0]       fetch_addr;
   logic [FET_W-1:0]  fetched;
   logic [CNT_W-1:0]  outstanding;
   logic [DIS_W-1:0]  discard;
   logic              flush_pend;
   pixel_t            rgb;
   pixel_t            fifo_head;
   logic [CNT_W-1:0]  fifo_count;
   logic              frame, accept, issue, drop_word;
   logic              fifo_push, fifo_pop, pop_req;
   logic              sel;
   logic [31:0]       frame_base;
   logic [7:0]        unused_data;

`ifdef LCD_FETCH_DOUBLE_BUFFER_EN
   assign sel = fb_select;
`else
   logic unused_sel;
   assign unused_sel = fb_select;
   assign sel        = 1'b0;
`endif

   // fetch_addr is reloaded only at next_frame, so it doubles as the latched page select
   assign frame_base  = sel ? FB_BASE1 : FB_BASE;
   assign unused_data = avm_readdata[31:24];

   assign frame     = tick && next_frame;
   assign accept    = avm_read && !avm_waitrequest;
   assign issue     = (32'(fifo_count) + 32'(outstanding) + BURST <= FIFO_DEPTH)
                      && (32'(fetched) < TOTAL);
   assign drop_word = avm_readdatavalid && (discard != '0);
   assign fifo_push = avm_readdatavalid && !drop_word && !frame;
   assign pop_req   = tick && data_enable && !frame;
   assign fifo_pop  = pop_req && (fifo_count != '0);

   pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_data (avm_readdata[23:0]),
      .pop       (fifo_pop),
      .flush     (frame),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (frame) state_next = FLUSH;
                  else if (issue) state_next = REQ;
         REQ:     if (accept) state_next = (frame || flush_pend) ? FLUSH : IDLE;
         FLUSH:   if (!frame && discard == '0) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      avm_read       = (state == REQ);
      avm_burstcount = 6'(BURST);
   end

   // A request caught by next_frame stays on the bus; its burst is dropped on acceptance
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         avm_address <= FB_BASE;
         fetch_addr  <= FB_BASE;
         fetched     <= '0;
         outstanding <= '0;
         discard     <= '0;
         flush_pend  <= 1'b0;
         underflow   <= 1'b0;
         rgb         <= '0;
      end else begin
         if (state == IDLE && state_next == REQ) avm_address <= fetch_addr;
         if (frame) begin
            fetch_addr  <= frame_base;
            fetched     <= '0;
            outstanding <= '0;
            underflow   <= 1'b0;
            discard     <= discard + DIS_W'(outstanding)
                           + (accept ? DIS_W'(BURST) : '0) - DIS_W'(avm_readdatavalid);
            flush_pend  <= (state == REQ) && !accept;
         end else begin
            if (accept && !flush_pend) begin
               fetch_addr <= fetch_addr + 4 * BURST;
               fetched    <= fetched + FET_W'(BURST);
            end
            outstanding <= outstanding + ((accept && !flush_pend) ? CNT_W'(BURST) : '0)
                           - CNT_W'(fifo_push);
            discard     <= discard + ((accept && flush_pend) ? DIS_W'(BURST) : '0)
                           - DIS_W'(drop_word);
            if (accept) flush_pend <= 1'b0;
            if (pop_req) begin
               if (fifo_count != '0) begin
                  rgb <= fifo_head;
               end else begin
                  rgb       <= UNDERFLOW_COLOR;
                  underflow <= 1'b1;
               end
            end
         end
      end
   end

   assign lcd_red   = rgb[RED_HI:RED_LO];
   assign lcd_green = rgb[GREEN_HI:GREEN_LO];
   assign lcd_blue  = rgb[BLUE_HI:BLUE_LO];

endmodule

// File: tb/tb_lcd_pixel_fetch.sv
// Bench for lcd_pixel_fetch: scenario table plus hand sequences, checked against
// a frame-level model (per-frame pixel queue, epoch-tagged bursts, Avalon slave).
module tb_lcd_pixel_fetch;

   localparam int          H     = 16;
   localparam int          V     = 4;
   localparam int          DEPTH = 32;
   localparam int          BURST = 8;
   localparam int          TOTAL = H * V;
   localparam logic [31:0] BASE0 = 32'h0000_0000;
   localparam logic [31:0] BASE1 = 32'h0020_0000;
   localparam logic [23:0] UFC   = 24'hFF00FF;
`ifdef LCD_FETCH_DOUBLE_BUFFER_EN
   localparam bit DB = 1'b1;
`else
   localparam bit DB = 1'b0;
`endif

   logic        clock, reset_n, tick, data_enable, next_frame, fb_select;
   logic [31:0] avm_address, avm_readdata;
   logic        avm_read, avm_waitrequest, avm_readdatavalid, underflow;
   logic [5:0]  avm_burstcount;
   logic [7:0]  lcd_red, lcd_green, lcd_blue;

   lcd_pixel_fetch #(
      .FB_BASE(BASE0), .FB_BASE1(BASE1), .H_ACT(H), .V_ACT(V),
      .FIFO_DEPTH(DEPTH), .BURST(BURST), .UNDERFLOW_COLOR(UFC)
   ) dut (
      .clock(clock), .reset_n(reset_n), .tick(tick), .data_enable(data_enable),
      .next_frame(next_frame), .fb_select(fb_select),
      .avm_address(avm_address), .avm_read(avm_read), .avm_burstcount(avm_burstcount),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
      .avm_readdatavalid(avm_readdatavalid),
      .lcd_red(lcd_red), .lcd_green(lcd_green), .lcd_blue(lcd_blue), .underflow(underflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] addr;
      int          ep;
      int          ready;
      int          sent;
   } burst_t;

   typedef struct {
      int lat;
      int wait_pct;
      int rdv_pct;
      int stall;
      int tick_div;
      bit fbsel;
      bit exp_uf;
      int exp_bursts;
   } scen_t;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int epoch = 0;
   logic [31:0] base_exp = BASE0;
   logic [23:0] pix_q[$];
   logic [23:0] exp_rgb = '0;
   logic        exp_uf = 1'b0;
   int          bursts_frame = 0;
   logic [31:0] first_addr = '0;
   bit          uf_seen = 1'b0;
   int          frame_pops = 0;
   bit          pend_first = 1'b0;
   logic [23:0] got_first = '0;
   burst_t      rq[$];
   int          lat = 2, wait_pct = 0, rdv_pct = 100, stall = 0;
   bit          req_active = 1'b0, just_acc = 1'b0;
   logic [31:0] cap_addr = '0;
   int          cap_ep = 0, stall_left = 0, stall_seen = 0;
   int          cur_words_out = 0;
   int          stale_words = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input logic t, input logic de, input logic nf);
      logic        w, rv, acc;
      logic [31:0] data, waddr;
      int          ep;
      @(negedge clock);
      cyc++;
      chk("rgb", {8'h00, lcd_red, lcd_green, lcd_blue}, {8'h00, exp_rgb});
      chk("underflow", {31'd0, underflow}, {31'd0, exp_uf});
      if (pend_first) begin
         got_first  = {lcd_red, lcd_green, lcd_blue};
         pend_first = 1'b0;
      end
      if (just_acc) begin
         chk("read_drop", {31'd0, avm_read}, 32'd0);
         just_acc = 1'b0;
      end else if (req_active) begin
         chk("read_held", {31'd0, avm_read}, 32'd1);
         chk("addr_held", avm_address, cap_addr);
         chk("burstcount", {26'd0, avm_burstcount}, BURST);
      end else if (avm_read) begin
         req_active = 1'b1;
         cap_addr   = avm_address;
         cap_ep     = epoch;
         stall_left = stall;
         stall_seen = 0;
      end

      tick = t; data_enable = de; next_frame = nf;
      if (req_active) begin
         if (stall > 0) begin
            w = (stall_left > 0);
            if (w) begin stall_left--; stall_seen++; end
         end else begin
            w = ($urandom_range(0, 99) < wait_pct);
         end
      end else begin
         w = 1'($urandom_range(0, 1));
      end
      avm_waitrequest = w;
      acc = req_active && !w;
      rv = 1'b0; ep = -1;
      data = $urandom;
      if (rq.size() > 0 && rq[0].ready <= cyc && $urandom_range(0, 99) < rdv_pct) begin
         rv    = 1'b1;
         waddr = rq[0].addr + 32'(4 * rq[0].sent);
         data  = {8'($urandom_range(0, 255)), 24'(waddr >> 2)};
         ep    = rq[0].ep;
         rq[0].sent = rq[0].sent + 1;
         if (rq[0].sent == BURST) void'(rq.pop_front());
      end
      avm_readdatavalid = rv;
      avm_readdata      = data;

      if (t && nf) begin
         epoch++;
         pix_q.delete();
         exp_uf        = 1'b0;
         base_exp      = (DB && fb_select) ? BASE1 : BASE0;
         bursts_frame  = 0;
         cur_words_out = 0;
         frame_pops    = 0;
         uf_seen       = 1'b0;
      end else if (t && de) begin
         if (frame_pops == 0) pend_first = 1'b1;
         frame_pops++;
         if (pix_q.size() == 0) begin
            exp_rgb = UFC; exp_uf = 1'b1; uf_seen = 1'b1;
         end else begin
            exp_rgb = pix_q.pop_front();
         end
      end
      if (rv) begin
         if (ep == epoch) begin
            pix_q.push_back(data[23:0]);
            cur_words_out--;
            chk("fifo_bound", {31'd0, pix_q.size() <= DEPTH}, 32'd1);
         end else begin
            stale_words++;
         end
      end
      if (acc) begin
         req_active = 1'b0;
         just_acc   = 1'b1;
         if (stall > 0) chk("stall_cycles", stall_seen, stall);
         rq.push_back('{cap_addr, cap_ep, cyc + lat, 0});
         if (cap_ep == epoch) begin
            chk("burst_addr", cap_addr, base_exp + 32'(4 * BURST * bursts_frame));
            if (bursts_frame == 0) first_addr = cap_addr;
            bursts_frame++;
            cur_words_out += BURST;
         end
      end
   endtask

   task automatic run_frame(input int td, input bit tog, input bit chk_first);
      logic [31:0] b;
      int p;
      b = (DB && fb_select) ? BASE1 : BASE0;
      step(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 40 * td; i++) step(i % td == 0, 1'b0, 1'b0);
      p = 0;
      for (int c = 0; p < TOTAL; c++) begin
         if (c % td == 0) begin
            step(1'b1, 1'b1, 1'b0);
            p++;
            if (tog && p == TOTAL / 2) fb_select = ~fb_select;
         end else begin
            step(1'b0, 1'b0, 1'b0);
         end
      end
      for (int i = 0; i < 3000 && (rq.size() != 0 || req_active || avm_read); i++)
         step(1'b0, 1'b0, 1'b0);
      chk("drain_done", {31'd0, rq.size() == 0 && !req_active && !avm_read}, 32'd1);
      repeat (20) step(1'b0, 1'b0, 1'b0);
      if (chk_first) chk("first_pixel", {8'h00, got_first}, {8'h00, 24'(b >> 2)});
      chk("first_addr", first_addr, b);
   endtask

   scen_t tbl[5];
   int    sb;

   initial begin
      tbl[0] = '{2,   0,  100, 0, 4, 1'b0, 1'b0, TOTAL / BURST};
      tbl[1] = '{5,   25, 90,  0, 4, 1'b1, 1'b0, TOTAL / BURST};
      tbl[2] = '{1,   0,  100, 5, 4, 1'b0, 1'b0, TOTAL / BURST};
      tbl[3] = '{400, 0,  100, 0, 1, 1'b0, 1'b1, DEPTH / BURST};
      tbl[4] = '{3,   40, 80,  0, 3, 1'b1, 1'b0, TOTAL / BURST};

      reset_n = 1'b0; tick = 1'b0; data_enable = 1'b0; next_frame = 1'b0; fb_select = 1'b0;
      avm_waitrequest = 1'b1; avm_readdata = '0; avm_readdatavalid = 1'b0;
      repeat (3) @(negedge clock);
      chk("reset_read", {31'd0, avm_read}, 32'd0);
      chk("reset_addr", avm_address, BASE0);
      chk("reset_rgb", {8'h00, lcd_red, lcd_green, lcd_blue}, 32'd0);
      chk("reset_underflow", {31'd0, underflow}, 32'd0);
      reset_n = 1'b1;

      for (int s = 0; s < 5; s++) begin
         lat = tbl[s].lat; wait_pct = tbl[s].wait_pct; rdv_pct = tbl[s].rdv_pct;
         stall = tbl[s].stall;
         fb_select = tbl[s].fbsel;
         run_frame(tbl[s].tick_div, 1'b1, !tbl[s].exp_uf);
         chk("bursts_per_frame", bursts_frame, tbl[s].exp_bursts);
         chk("underflow_seen", {31'd0, uf_seen}, {31'd0, tbl[s].exp_uf});
         chk("underflow_sticky", {31'd0, underflow}, {31'd0, tbl[s].exp_uf});
      end

      step(1'b1, 1'b0, 1'b1);
      chk("underflow_cleared", {31'd0, underflow}, 32'd0);

      lat = 60; wait_pct = 0; rdv_pct = 100; stall = 0; fb_select = 1'b0;
      step(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 300 && cur_words_out < 2 * BURST; i++) step(1'b0, 1'b0, 1'b0);
      chk("two_bursts_out", cur_words_out, 2 * BURST);
      sb = stale_words;
      lat = 2;
      run_frame(4, 1'b0, 1'b1);
      chk("stale_discarded", stale_words - sb, 2 * BURST);
      chk("bursts_after_abort", bursts_frame, TOTAL / BURST);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
